if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives instruction memory, loads IF/ID.
//  Consumes takebranch/branch_target from ID-stage branch resolution (predict-not-taken) and stall from the hazard unit.
//  Tolerates multi-cycle imem (req/ready); one-entry hold buffer absorbs a fetch that completes while stalled.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  word written to IF/ID on flush/bubble (sll $0,$0,0)
// PORTS
//  clock          in   1   pipeline clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  stall          in   1   hazard unit: hold PC and IF/ID this cycle
//  takebranch     in   1   ID: branch in IF/ID resolved taken (ignored while stall=1)
//  branch_target  in   32  ID: redirect address; bits[1:0] forced to 0
//  imem_req       out  1   fetch request; held with stable imem_addr until imem_ready
//  imem_addr      out  32  fetch address
//  imem_ready     in   1   imem_rdata valid this cycle; completes the request
//  imem_rdata     in   32  fetched instruction
//  ifid_ir        out  32  IF/ID instruction
//  ifid_pc4       out  32  IF/ID PC+4 of that instruction
//  ifid_valid     out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, state=BOOT, imem_req=0, ifid_ir=NOP_INSTR, ifid_pc4=0, ifid_valid=0, tgt_q=0, hold_q=0.
//  States: BOOT, FETCH, HOLD, DROP.
//  BOOT: imem_req=0; next cycle -> FETCH (first request 1 cycle after reset_n rises).
//  FETCH: imem_req=1, imem_addr=pc. Priority each cycle:
//   1 stall & ready: hold_q<=rdata; -> HOLD. pc and IF/ID unchanged.
//   2 stall & !ready: all held, stay FETCH (request stays up).
//   3 takebranch & ready: IF/ID<=bubble; pc<=target; stay FETCH.
//   4 takebranch & !ready: IF/ID<=bubble; tgt_q<=target; -> DROP.
//   5 ready: IF/ID<={rdata, pc+4, 1}; pc<=pc+4.
//   6 !ready: IF/ID<=bubble (ID sees NOP while imem waits); pc held.
//  HOLD: imem_req=0. stall=1: hold. stall=0: IF/ID<={hold_q, pc+4, 1}; pc<=pc+4; -> FETCH.
//   (takebranch cannot coincide: ID is frozen while stall=1; ignored in HOLD.)
//  DROP: imem_req=1, imem_addr=pc (old outstanding address, must not change).
//   IF/ID=bubble every cycle. ready: discard rdata; pc<=tgt_q; -> FETCH. stall ignored.
//  Bubble = {NOP_INSTR, 32'h0, 0}.
//  Latency: zero-wait imem -> one instruction per cycle, IF/ID loaded on the edge ready is seen.
//  Taken branch costs 1 bubble with zero-wait imem; +N cycles if the wrong-path fetch is N-cycle slow.
//  Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no trap).
//  imem_addr/imem_req change only on clock edges (registered state); addr stable while req=1 and !ready.
//  reset_n mid-request: request abandoned, imem_req drops asynchronously; imem must tolerate this.
// STRUCTURE
//  Shared include mips_defs.vh: fetch state encodings (BOOT/FETCH/HOLD/DROP), NOP_INSTR default,
//   RESET_PC default, instruction width 32.
//  Sub-module if_hold_buffer: one-entry 32-bit register + full flag (load/unload/clear), used for hold_q.
//  Rest (PC, FSM, IF/ID register) stays in this file.
// TESTING
//  T1 reset: reset_n=0 async mid-cycle -> ifid_valid=0, ifid_ir=0, imem_req=0 at once; first addr 0x0 one cycle after release.
//  T2 streaming: ready=1 always, words 0xA0..0xA3 -> IF/ID gets them on consecutive edges, ifid_pc4=4,8,12,16.
//  T3 taken branch: takebranch=1, target=0x100 while fetching 0x8 (ready=1) -> one bubble, next fetch 0x100, ifid_pc4=0x104.
//  T4 redirect during wait: fetch 0x8 ready=0 for 3 cycles, takebranch target 0x40 in cycle 1 -> DROP; addr stays 0x8;
//     word at 0x8 discarded; next req addr 0x40; ifid_valid=0 throughout.
//  T5 stall + ready: stall=1 2 cycles, ready=1 first cycle with 0xDEAD -> req drops, IF/ID held; stall=0 -> ifid_ir=0xDEAD,
//     pc advances once; no refetch of that address.
//  T6 wrap: RESET_PC=0xFFFF_FFFC, ready=1 -> ifid_pc4=0x0, next imem_addr=0x0; target 0x103 -> fetch 0x100.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF stage: fetch FSM states, default reset PC and NOP encoding.
package if_fetch_stage_pkg;

    localparam int unsigned InstrWidth = 32;

    localparam logic [31:0] ResetPcDefault  = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [31:0] NopInstrDefault = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StDrop  = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry register with a full flag; parks an instruction that returns while the pipe is stalled.
module if_hold_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic                  unload_i,
    input  logic                  clear_i,
    input  logic [InstrWidth-1:0] data_i,
    output logic [InstrWidth-1:0] data_o,
    output logic                  full_o
);

    logic [InstrWidth-1:0] data_q;
    logic                  full_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, imem request handshake, branch redirect and IF/ID pipeline register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = ResetPcDefault,
    parameter logic [31:0] NOP_INSTR = NopInstrDefault
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        takebranch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic         hold_load;
    logic         hold_unload;
    logic [31:0]  hold_data;
    logic         hold_full;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    if_hold_buffer u_hold_buffer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_i   (hold_load),
        .unload_i (hold_unload),
        .clear_i  (1'b0),
        .data_i   (imem_rdata),
        .data_o   (hold_data),
        .full_o   (hold_full)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        ir_d        = ir_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (stall) begin
                    // A word returning under stall is parked; otherwise the request just waits.
                    if (imem_ready) begin
                        hold_load = 1'b1;
                        state_d   = StHold;
                    end
                end else if (takebranch) begin
                    ir_d    = NOP_INSTR;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = align_word(branch_target);
                    end else begin
                        tgt_d   = align_word(branch_target);
                        state_d = StDrop;
                    end
                end else if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    ir_d    = NOP_INSTR;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end
            end
            StHold: begin
                if (!stall) begin
                    ir_d        = hold_data;
                    pc4_d       = pc_plus4;
                    valid_d     = hold_full;
                    pc_d        = pc_plus4;
                    hold_unload = 1'b1;
                    state_d     = StFetch;
                end
            end
            StDrop: begin
                // Wrong-path fetch still outstanding: keep its address until imem completes it.
                ir_d    = NOP_INSTR;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
                if (imem_ready) begin
                    pc_d    = tgt_q;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            ir_q    <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req   = (state_q == StFetch) || (state_q == StDrop);
    assign imem_addr  = pc_q;
    assign ifid_ir    = ir_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for the main flow plus reset and PC-wrap sequences.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        takebranch;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    logic        w_takebranch;
    logic [31:0] w_branch_target;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ready;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_ifid_ir;
    logic [31:0] w_ifid_pc4;
    logic        w_ifid_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .takebranch    (takebranch),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_ir       (ifid_ir),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid)
    );

    if_fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (1'b0),
        .takebranch    (w_takebranch),
        .branch_target (w_branch_target),
        .imem_req      (w_imem_req),
        .imem_addr     (w_imem_addr),
        .imem_ready    (w_imem_ready),
        .imem_rdata    (w_imem_rdata),
        .ifid_ir       (w_ifid_ir),
        .ifid_pc4      (w_ifid_pc4),
        .ifid_valid    (w_ifid_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        tb;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        valid;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //          stall tb  tgt            rdy rdata           req addr           ir              pc4            valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        32'h0,   1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hA0,       1'b1, 32'h0,   32'hA0,       32'h4,   1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hA1,       1'b1, 32'h4,   32'hA1,       32'h8,   1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hA2,       1'b1, 32'h8,   32'hA2,       32'hC,   1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hA3,       1'b1, 32'hC,   32'hA3,       32'h10,  1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h100,   1'b1, 32'hA4,       1'b1, 32'h10,  32'h0,        32'h0,   1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hB0,       1'b1, 32'h100, 32'hB0,       32'h104, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h40,    1'b0, 32'h0,        1'b1, 32'h104, 32'h0,        32'h0,   1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b1, 32'h104, 32'h0,        32'h0,   1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b1, 32'h104, 32'h0,        32'h0,   1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hDEADBEEF, 1'b1, 32'h104, 32'h0,        32'h0,   1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC0,       1'b1, 32'h40,  32'hC0,       32'h44,  1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC1,       1'b1, 32'h44,  32'hC1,       32'h48,  1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hDEAD,     1'b1, 32'h48,  32'hC1,       32'h48,  1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hBAD0,     1'b0, 32'h48,  32'hC1,       32'h48,  1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 32'h48,  32'hDEAD,     32'h4C,  1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b1, 32'h4C,  32'h0,        32'h0,   1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b1, 32'h4C,  32'h0,        32'h0,   1'b0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hD0,       1'b1, 32'h4C,  32'hD0,       32'h50,  1'b1};
        vecs[19] = '{1'b0, 1'b1, 32'h103,   1'b1, 32'hD1,       1'b1, 32'h50,  32'h0,        32'h0,   1'b0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hE0,       1'b1, 32'h100, 32'hE0,       32'h104, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 32'h200,   1'b0, 32'h0,        1'b1, 32'h104, 32'hE0,       32'h104, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hE1,       1'b1, 32'h104, 32'hE1,       32'h108, 1'b1};

        reset_n         = 1'b0;
        stall           = 1'b0;
        takebranch      = 1'b0;
        branch_target   = 32'h0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        w_takebranch    = 1'b0;
        w_branch_target = 32'h0;
        w_imem_ready    = 1'b0;
        w_imem_rdata    = 32'h0;

        #2;
        chk("reset req", {31'h0, imem_req}, 32'h0);
        chk("reset valid", {31'h0, ifid_valid}, 32'h0);
        chk("reset ir", ifid_ir, 32'h0);
        chk("reset pc4", ifid_pc4, 32'h0);
        chk("reset addr", imem_addr, 32'h0);

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clock);
            stall         = vecs[i].stall;
            takebranch    = vecs[i].tb;
            branch_target = vecs[i].tgt;
            imem_ready    = vecs[i].ready;
            imem_rdata    = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
            chk($sformatf("v%0d addr", i), imem_addr, vecs[i].addr);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d ir", i), ifid_ir, vecs[i].ir);
            chk($sformatf("v%0d pc4", i), ifid_pc4, vecs[i].pc4);
            chk($sformatf("v%0d valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].valid});
        end

        // Asynchronous reset mid-cycle while a valid instruction sits in IF/ID and a request is up.
        @(negedge clock);
        stall      = 1'b0;
        takebranch = 1'b0;
        imem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async rst req", {31'h0, imem_req}, 32'h0);
        chk("async rst valid", {31'h0, ifid_valid}, 32'h0);
        chk("async rst ir", ifid_ir, 32'h0);
        chk("async rst pc4", ifid_pc4, 32'h0);
        chk("async rst addr", imem_addr, 32'h0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // PC wrap on the RESET_PC=0xFFFF_FFFC instance, then a misaligned branch target.
        @(negedge clock);
        #1;
        chk("wrap boot req", {31'h0, w_imem_req}, 32'h0);
        chk("wrap boot addr", w_imem_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        w_imem_ready = 1'b1;
        w_imem_rdata = 32'hF0;
        #1;
        chk("wrap req", {31'h0, w_imem_req}, 32'h1);
        chk("wrap addr0", w_imem_addr, 32'hFFFF_FFFC);
        @(posedge clock);
        #1;
        chk("wrap ir0", w_ifid_ir, 32'hF0);
        chk("wrap pc4 0", w_ifid_pc4, 32'h0);
        chk("wrap valid0", {31'h0, w_ifid_valid}, 32'h1);
        @(negedge clock);
        w_imem_rdata = 32'hF1;
        #1;
        chk("wrap addr1", w_imem_addr, 32'h0);
        @(posedge clock);
        #1;
        chk("wrap ir1", w_ifid_ir, 32'hF1);
        chk("wrap pc4 1", w_ifid_pc4, 32'h4);
        @(negedge clock);
        w_takebranch    = 1'b1;
        w_branch_target = 32'h103;
        w_imem_rdata    = 32'hF2;
        @(posedge clock);
        #1;
        chk("wrap br valid", {31'h0, w_ifid_valid}, 32'h0);
        chk("wrap br ir", w_ifid_ir, 32'h0);
        @(negedge clock);
        w_takebranch = 1'b0;
        w_imem_rdata = 32'hF3;
        #1;
        chk("wrap br addr", w_imem_addr, 32'h100);
        @(posedge clock);
        #1;
        chk("wrap br ir2", w_ifid_ir, 32'hF3);
        chk("wrap br pc4", w_ifid_pc4, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
